// File: rtl/key_module256_if.sv
// Round-key request/response bundle for key_module256.
interface key_module256_if;
  logic [255:0] key;
  logic [1:0]   Algorithm;
  logic [3:0]   i;
  logic [127:0] out;

  modport master (output key, output Algorithm, output i, input out);
  modport slave  (input key, input Algorithm, input i, output out);
endinterface

// File: rtl/key_module256.sv
// AES-256 round-key generator: combinational key expansion, registered key select.
module key_module256 (
  input logic            clk,
  input logic            rst_n,
  key_module256_if.slave bus
);

  // Forward S-box; entry 0 sits in the most-significant byte.
  localparam logic [2047:0] Sbox = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    // Byte b lives at bit offset 8*(255-b); ~b == 255-b for 8 bits.
    return Sbox[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  logic [31:0]  w  [60];
  logic [127:0] rk [16];
  logic [127:0] out_d;
  logic [127:0] out_q;

  // Expand the key into w0..w59, group into round keys and select the next output.
  always_comb begin
    logic [31:0] t;
    t = '0;
    for (int k = 0; k < 8; k++) begin
      w[k] = bus.key[255 - 32 * k -: 32];
    end
    for (int k = 8; k < 60; k++) begin
      t = w[k-1];
      if (k % 8 == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {8'h01 << (k / 8 - 1), 24'h0};
      end else if (k % 8 == 4) begin
        t = sub_word(t);
      end
      w[k] = w[k-8] ^ t;
    end
    for (int r = 0; r < 15; r++) begin
      rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
    // Index 15 is out of range and reads as zero.
    rk[15] = '0;
    out_d = (bus.Algorithm == 2'b01) ? rk[bus.i] : '0;
  end

  // Output register; asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign bus.out = out_q;

endmodule

// File: tb/tb_key_module256.sv
// Self-checking bench for key_module256: FIPS-197 vectors, mode/range gates,
// reset behaviour and random keys against an arithmetic reference model.
module tb_key_module256;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  key_module256_if bus ();

  key_module256 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]   sb [256];
  logic [127:0] fips [15];
  logic [255:0] fips_key;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int n = 0; n < 8; n++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int c = 1; c < 256; c++) begin
        if (x != 0 && gmul(8'(x), 8'(c)) == 8'h01) inv = 8'(c);
      end
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sb[x] = s;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
  endfunction

  function automatic logic [127:0] model(input logic [255:0] k, input logic [1:0] alg,
                                         input logic [3:0] r);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int          ri;
    if (alg != 2'b01 || r == 4'd15) return '0;
    for (int n = 0; n < 8; n++) w[n] = k[255 - 32 * n -: 32];
    rc = 8'h01;
    for (int n = 8; n < 60; n++) begin
      t = w[n-1];
      if (n % 8 == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (n % 8 == 4) begin
        t = subw(t);
      end
      w[n] = w[n-8] ^ t;
    end
    ri = int'(r);
    return {w[4*ri], w[4*ri+1], w[4*ri+2], w[4*ri+3]};
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [255:0] rkey;
    logic [1:0]   ralg;
    logic [3:0]   ri;
    n_cmp = 0;
    n_err = 0;
    fips_key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    fips[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    fips[1]  = 128'h101112131415161718191a1b1c1d1e1f;
    fips[2]  = 128'ha573c29fa176c498a97fce93a572c09c;
    fips[3]  = 128'h1651a8cd0244beda1a5da4c10640bade;
    fips[4]  = 128'hae87dff00ff11b68a68ed5fb03fc1567;
    fips[5]  = 128'h6de1f1486fa54f9275f8eb5373b8518d;
    fips[6]  = 128'hc656827fc9a799176f294cec6cd5598b;
    fips[7]  = 128'h3de23a75524775e727bf9eb45407cf39;
    fips[8]  = 128'h0bdc905fc27b0948ad5245a4c1871c2f;
    fips[9]  = 128'h45f5a66017b2d387300d4d33640a820a;
    fips[10] = 128'h7ccff71cbeb4fe5413e6bbf0d261a7df;
    fips[11] = 128'hf01afafee7a82979d7a5644ab3afe640;
    fips[12] = 128'h2541fe719bf500258813bbd55a721c0a;
    fips[13] = 128'h4e5a6699a9f24fe07e572baacdf8cdea;
    fips[14] = 128'h24fc79ccbf0979e9371ac23c6d68de36;
    build_sbox();

    // Reset held with live inputs.
    rst_n = 1'b1;
    bus.key = fips_key;
    bus.Algorithm = 2'b01;
    bus.i = 4'd4;
    #1 rst_n = 1'b0;
    #1 check("reset_async", bus.out, 128'h0);
    step();
    check("reset_hold0", bus.out, 128'h0);
    step();
    check("reset_hold1", bus.out, 128'h0);
    rst_n = 1'b1;
    step();
    check("reset_release", bus.out, fips[4]);

    // FIPS-197 sweep with a mid-run reset pulse before i=7.
    for (int r = 0; r < 15; r++) begin
      bus.i = 4'(r);
      if (r == 7) begin
        #1 rst_n = 1'b0;
        #1 check("midrun_reset", bus.out, 128'h0);
        #1 rst_n = 1'b1;
      end
      step();
      check($sformatf("fips_i%0d", r), bus.out, fips[r]);
    end

    bus.i = 4'd15;
    step();
    check("range_i15", bus.out, 128'h0);

    // Mode gate at i=3.
    bus.i = 4'd3;
    for (int m = 0; m < 4; m++) begin
      if (m == 1) continue;
      bus.Algorithm = 2'(m);
      step();
      check($sformatf("mode_%0d", m), bus.out, 128'h0);
    end
    bus.Algorithm = 2'b01;
    step();
    check("mode_return", bus.out, fips[3]);

    // Key change to all-zero at i=2.
    bus.i = 4'd2;
    step();
    check("zero_key_pre", bus.out, fips[2]);
    bus.key = '0;
    step();
    check("zero_key", bus.out, 128'h62636363626363636263636362636363);

    // Random keys, modes and indices against the reference model.
    for (int n = 0; n < 200; n++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      ralg = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
      ri = 4'($urandom_range(0, 15));
      bus.key = rkey;
      bus.Algorithm = ralg;
      bus.i = ri;
      step();
      check($sformatf("rand%0d_a%0d_i%0d", n, ralg, ri), bus.out, model(rkey, ralg, ri));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
